// File: rtl/floo_wormhole_arbiter.sv
// Round-robin wormhole arbiter sharing one router output among NumInputs inputs.
// A packet keeps the grant from its first offer until its tail flit handshakes.
package floo_wormhole_pkg;
  typedef struct packed {
    logic last;
  } hdr_t;

  typedef struct packed {
    hdr_t       hdr;
    logic [7:0] payload;
  } flit_t;
endpackage

// state  | meaning
// IDLE   | no packet owns the output; round-robin search from rr_ptr
// LOCKED | output owned by lock_idx until its tail flit handshakes
module floo_wormhole_arbiter #(
  parameter int unsigned NumInputs = 5,
  parameter type         flit_t    = floo_wormhole_pkg::flit_t,
  parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumInputs-1:0] valid_i,
  output logic [NumInputs-1:0] ready_o,
  input  flit_t [NumInputs-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output flit_t                data_o,
  output logic [IdxWidth-1:0]  gnt_idx_o,
  output logic                 locked_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumInputs - 1);
  localparam logic [IdxWidth:0]   NumExt  = (IdxWidth + 1)'(NumInputs);

  state_e              state_q;
  logic [IdxWidth-1:0] rr_ptr_q, lock_idx_q;
  logic [IdxWidth-1:0] rr_gnt, gnt, gnt_next;
  logic [IdxWidth:0]   cand;
  logic                hs, tail_hs;

  // Walk candidates from the far end so the one closest to rr_ptr wins.
  always_comb begin
    rr_gnt = rr_ptr_q;
    cand   = '0;
    for (int k = NumInputs - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IdxWidth + 1)'(k);
      if (cand >= NumExt) cand = cand - NumExt;
      if (valid_i[cand[IdxWidth-1:0]]) rr_gnt = cand[IdxWidth-1:0];
    end
  end

  assign gnt       = (state_q == LOCKED) ? lock_idx_q : rr_gnt;
  assign valid_o   = (state_q == LOCKED) ? valid_i[lock_idx_q] : |valid_i;
  assign data_o    = data_i[gnt];
  assign hs        = valid_o & ready_i;
  assign tail_hs   = hs & data_o.hdr.last;
  assign gnt_next  = (gnt == LastIdx) ? '0 : gnt + IdxWidth'(1);
  assign gnt_idx_o = gnt;
  assign locked_o  = (state_q == LOCKED);

  always_comb begin
    ready_o      = '0;
    ready_o[gnt] = ready_i & valid_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tail_hs) begin
            rr_ptr_q <= gnt_next;
          end else if (valid_o) begin
            state_q    <= LOCKED;
            lock_idx_q <= gnt;
          end
        end
        LOCKED: begin
          if (tail_hs) begin
            state_q  <= IDLE;
            rr_ptr_q <= gnt_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef TARGET_SYNTHESIS
  logic                pend_q, stall_q;
  logic [IdxWidth-1:0] stall_gnt_q;
  flit_t               stall_data_q;

  // pend_q: a packet was offered last cycle and its tail has not yet handshaken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q       <= 1'b0;
      stall_q      <= 1'b0;
      stall_gnt_q  <= '0;
      stall_data_q <= '0;
    end else begin
      pend_q       <= valid_o & ~tail_hs;
      stall_q      <= valid_o & ~ready_i;
      stall_gnt_q  <= gnt;
      stall_data_q <= data_o;
      if (pend_q && state_q == LOCKED && !valid_o)
        $error("locked input %0d dropped valid before its tail", lock_idx_q);
      if (stall_q && data_i[stall_gnt_q] != stall_data_q)
        $error("granted input %0d changed data while stalled", stall_gnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// Bench for floo_wormhole_arbiter: directed scenarios plus random traffic checked
// against a packet-ownership model (owner input / round-robin pointer).
module tb_floo_wormhole_arbiter;
  import floo_wormhole_pkg::*;

  localparam int N  = 5;
  localparam int IW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  valid_i, ready_o;
  flit_t [N-1:0] data_i;
  logic          valid_o, ready_i, locked_o;
  flit_t         data_o;
  logic [IW-1:0] gnt_idx_o;

  floo_wormhole_arbiter #(.NumInputs(N)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .gnt_idx_o(gnt_idx_o),
    .locked_o (locked_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [N-1:0]  drv_v;
  flit_t         drv_d [N];
  logic          drv_rdy, drv_rst;
  int            rem [N];
  int            refill;
  int            m_owner, m_ptr;
  logic [IW-1:0] obs_g;
  logic          obs_lock, obs_v;
  flit_t         obs_d;
  logic [N-1:0]  obs_rdy;
  bit            hs;
  int            eg;
  flit_t         f3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_gnt();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < N; k++)
      if (drv_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return m_ptr;
  endfunction

  task automatic new_flit(input int i, input bit last);
    drv_d[i].hdr.last = last;
    drv_d[i].payload  = 8'($urandom);
  endtask

  task automatic start_pkt(input int i, input int len);
    drv_v[i] = 1'b1;
    rem[i]   = len;
    new_flit(i, len == 1);
  endtask

  task automatic clear_all();
    drv_v = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
  endtask

  // Apply drives, check one cycle against the model, then step the model.
  task automatic run_cycle(input string tag);
    bit           ev;
    logic [N-1:0] er;
    rst_ni  = drv_rst;
    ready_i = drv_rdy;
    valid_i = drv_v;
    for (int i = 0; i < N; i++) data_i[i] = drv_d[i];
    @(negedge clk_i);
    obs_g = gnt_idx_o; obs_lock = locked_o; obs_d = data_o;
    obs_rdy = ready_o; obs_v = valid_o;
    hs = 1'b0;
    eg = model_gnt();
    ev = (m_owner >= 0) ? drv_v[m_owner] : (|drv_v);
    if (drv_rst) begin
      er = '0;
      if (ev && drv_rdy) er[eg] = 1'b1;
      hs = ev && drv_rdy;
      chk({tag, ".valid"},  32'(valid_o),  32'(ev));
      chk({tag, ".gnt"},    32'(gnt_idx_o), 32'(eg));
      chk({tag, ".locked"}, 32'(locked_o), 32'(m_owner >= 0));
      chk({tag, ".ready"},  32'(ready_o),  32'(er));
      if (ev) chk({tag, ".data"}, 32'(data_o), 32'(drv_d[eg]));
    end
    @(posedge clk_i);
    #1;
    if (!drv_rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (ev) begin
      if (hs && drv_d[eg].hdr.last) begin
        m_owner = -1;
        m_ptr   = (eg + 1) % N;
      end else begin
        m_owner = eg;
      end
    end
  endtask

  // Move stimulus on after a handshake: next flit, new packet or go idle.
  task automatic advance();
    if (hs) begin
      if (rem[eg] > 1) begin
        rem[eg]--;
        new_flit(eg, rem[eg] == 1);
      end else begin
        rem[eg]   = 0;
        drv_v[eg] = 1'b0;
        if (refill == 1) start_pkt(eg, 1);
        else if (refill == 2 && $urandom_range(0, 1) == 1) start_pkt(eg, $urandom_range(1, 4));
      end
    end
    if (refill == 2)
      for (int i = 0; i < N; i++)
        if (!drv_v[i] && $urandom_range(0, 3) == 0) start_pkt(i, $urandom_range(1, 4));
  endtask

  initial begin
    drv_rst = 1'b0; drv_rdy = 1'b0; drv_v = '0; refill = 0;
    m_owner = -1; m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      drv_d[i] = '0;
      rem[i]   = 0;
    end
    run_cycle("rst");
    run_cycle("rst");
    drv_rst = 1'b1;
    drv_rdy = 1'b1;
    run_cycle("reset_idle");
    chk("reset.gnt",    32'(obs_g),    32'd0);
    chk("reset.locked", 32'(obs_lock), 32'd0);
    chk("reset.ready",  32'(obs_rdy),  32'd0);

    // Two single-flit requesters alternate.
    refill = 1;
    start_pkt(0, 1); start_pkt(2, 1);
    for (int k = 0; k < 4; k++) begin
      run_cycle("t1");
      chk("t1.seq",  32'(obs_g),    32'((k % 2) * 2));
      chk("t1.lock", 32'(obs_lock), 32'd0);
      advance();
    end

    // Bring rr_ptr to 1, then a 3-flit packet on input 1 against input 0.
    refill = 0;
    clear_all();
    start_pkt(0, 1);
    run_cycle("t2pre");
    advance();
    start_pkt(0, 1); start_pkt(1, 3);
    for (int k = 0; k < 4; k++) begin
      run_cycle("t2");
      chk("t2.seq",  32'(obs_g),    32'((k < 3) ? 1 : 0));
      chk("t2.lock", 32'(obs_lock), 32'(k == 1 || k == 2));
      advance();
    end

    // Backpressure holds input 3 against a later request on input 0.
    clear_all();
    drv_rdy = 1'b0;
    start_pkt(3, 1);
    f3 = drv_d[3];
    run_cycle("t3a");
    chk("t3a.gnt", 32'(obs_g), 32'd3); chk("t3a.data", 32'(obs_d), 32'(f3));
    chk("t3a.ready", 32'(obs_rdy), 32'd0);
    advance();
    start_pkt(0, 1);
    run_cycle("t3b");
    chk("t3b.gnt", 32'(obs_g), 32'd3); chk("t3b.data", 32'(obs_d), 32'(f3));
    chk("t3b.ready", 32'(obs_rdy), 32'd0);
    advance();
    drv_rdy = 1'b1;
    run_cycle("t3c");
    chk("t3c.gnt", 32'(obs_g), 32'd3); chk("t3c.data", 32'(obs_d), 32'(f3));
    chk("t3c.ready", 32'(obs_rdy), 32'b01000);
    advance();
    run_cycle("t3d");
    chk("t3d.gnt", 32'(obs_g), 32'd0);
    advance();

    // rr_ptr to 4, then every input requests: 4 wraps to 0..4.
    start_pkt(3, 1);
    run_cycle("t4pre");
    advance();
    refill = 1;
    for (int i = 0; i < N; i++) start_pkt(i, 1);
    for (int k = 0; k < 6; k++) begin
      run_cycle("t4");
      chk("t4.seq", 32'(obs_g), 32'((4 + k) % N));
      advance();
    end

    // Reset in the middle of a locked packet.
    refill = 0;
    clear_all();
    start_pkt(2, 4);
    run_cycle("t5a");
    chk("t5a.lock", 32'(obs_lock), 32'd0);
    advance();
    run_cycle("t5b");
    chk("t5b.lock", 32'(obs_lock), 32'd1);
    chk("t5b.gnt",  32'(obs_g),    32'd2);
    advance();
    drv_rst = 1'b0;
    run_cycle("t5rst");
    drv_rst = 1'b1;
    clear_all();
    start_pkt(1, 1); start_pkt(3, 1);
    run_cycle("t5c");
    chk("t5c.lock", 32'(obs_lock), 32'd0);
    chk("t5c.gnt",  32'(obs_g),    32'd1);
    advance();
    run_cycle("t5d");
    chk("t5d.gnt", 32'(obs_g), 32'd3);
    advance();

    // Idle cycles leave rr_ptr (4) untouched.
    clear_all();
    for (int k = 0; k < 10; k++) begin
      run_cycle("t6");
      chk("t6.valid", 32'(obs_v),   32'd0);
      chk("t6.ready", 32'(obs_rdy), 32'd0);
    end
    for (int i = 0; i < N; i++) start_pkt(i, 1);
    run_cycle("t6end");
    chk("t6end.gnt", 32'(obs_g), 32'd4);
    advance();

    // Random multi-flit traffic with random backpressure.
    clear_all();
    refill = 2;
    for (int k = 0; k < 400; k++) begin
      drv_rdy = ($urandom_range(0, 3) != 0);
      run_cycle("rnd");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
